// File: rtl/spi_cmd_master_if.sv
// Host-side request/response bundle for the SPI command master.
// The host drives requests; the master returns handshake, response and status.
interface spi_cmd_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic       req_hi;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;

  modport master (
    output req_valid, req_write, req_hi, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_write, req_hi, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/spi_cmd_master.sv
// SPI mode-0 initiator: one request becomes a two-byte frame (instruction, data),
// returning the MISO byte seen during the data phase.
module spi_cmd_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_cmd_master_if.slave  host,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic             cs_n
);

  localparam int CNT_MAX = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_LOAD   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LOAD = CW'(CS_SETUP - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    bit_cnt, bit_nxt;
  logic          sclk_nxt, mosi_nxt, cs_n_nxt;
  logic          rsp_pulse, rsp_pulse_nxt;
  logic [7:0]    rsp_byte, rsp_byte_nxt;
  // Bit 15 of the frame goes straight to mosi at accept, so only 15 bits are kept.
  logic [14:0]   tx_sr, tx_nxt;
  logic [7:0]    rx_sr, rx_nxt;

  assign host.req_ready = (state == IDLE);
  assign host.busy      = (state != IDLE);
  assign host.rsp_valid = rsp_pulse;
  assign host.rsp_rdata = rsp_byte;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bit_nxt       = bit_cnt;
    sclk_nxt      = sclk;
    mosi_nxt      = mosi;
    cs_n_nxt      = cs_n;
    rsp_pulse_nxt = 1'b0;
    rsp_byte_nxt  = rsp_byte;
    tx_nxt        = tx_sr;
    rx_nxt        = rx_sr;
    unique case (state)
      IDLE: begin
        if (host.req_valid) begin
          tx_nxt    = {host.req_hi, host.req_addr,
                       (host.req_write ? host.req_wdata : 8'h00)};
          mosi_nxt  = host.req_write;
          cs_n_nxt  = 1'b0;
          cnt_nxt   = SETUP_LOAD;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          cnt_nxt   = DIV_LOAD;
          bit_nxt   = 4'd0;
          state_nxt = SHIFT;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          cnt_nxt = DIV_LOAD;
          if (!sclk) begin
            sclk_nxt = 1'b1;
            rx_nxt   = {rx_sr[6:0], miso};
          end else begin
            sclk_nxt = 1'b0;
            if (bit_cnt == 4'd15) begin
              cnt_nxt   = SETUP_LOAD;
              state_nxt = HOLD;
            end else begin
              bit_nxt  = bit_cnt + 4'd1;
              mosi_nxt = tx_sr[14];
              tx_nxt   = {tx_sr[13:0], 1'b0};
            end
          end
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          cs_n_nxt      = 1'b1;
          mosi_nxt      = 1'b0;
          rsp_pulse_nxt = 1'b1;
          rsp_byte_nxt  = rx_sr;
          cnt_nxt       = SETUP_LOAD;
          state_nxt     = GAP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and pin state: asynchronous reset so the bus is released immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= 4'd0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      cs_n      <= 1'b1;
      rsp_pulse <= 1'b0;
      rsp_byte  <= 8'h00;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_cnt   <= bit_nxt;
      sclk      <= sclk_nxt;
      mosi      <= mosi_nxt;
      cs_n      <= cs_n_nxt;
      rsp_pulse <= rsp_pulse_nxt;
      rsp_byte  <= rsp_byte_nxt;
    end
  end

  always_ff @(posedge clk) begin
    tx_sr <= tx_nxt;
    rx_sr <= rx_nxt;
  end

endmodule
